// File: rtl/router_arb_pkg.sv
// Shared definitions for the router output-port arbiter.
// FSM state encoding and the default channel count.
package router_arb_pkg;

  localparam int NUMBER_CHANNELS = 5;

  localparam logic ST_IDLE   = 1'b0;
  localparam logic ST_LOCKED = 1'b1;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: lowest priority is start_i,
// search begins at start_i+1. Ports: req_i, start_i -> gnt_o, idx_o, any_o.
module rr_pick #(
  parameter int N  = router_arb_pkg::NUMBER_CHANNELS,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] start_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);

  always_comb begin
    int c;
    logic found;
    c     = 0;
    found = 1'b0;
    gnt_o = '0;
    idx_o = '0;
    for (int k = 1; k <= N; k++) begin
      c = (int'(start_i) + k) % N;
      if (!found && req_i[c]) begin
        found    = 1'b1;
        gnt_o[c] = 1'b1;
        idx_o    = IW'(c);
      end
    end
    any_o = found;
  end

endmodule

// File: rtl/output_port_arbiter.sv
// Per-output-port packet arbiter: round-robin grant held head to tail.
// Ports: clk, rst_n, req, tail, out_ready -> sel, idle, out_valid, ack.
module output_port_arbiter #(
  parameter int NUMBER_CHANNELS = router_arb_pkg::NUMBER_CHANNELS
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUMBER_CHANNELS-1:0] req,
  input  logic [NUMBER_CHANNELS-1:0] tail,
  input  logic                       out_ready,
  output logic [NUMBER_CHANNELS-1:0] sel,
  output logic                       idle,
  output logic                       out_valid,
  output logic [NUMBER_CHANNELS-1:0] ack
);

  import router_arb_pkg::*;

  localparam int N  = NUMBER_CHANNELS;
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  logic          state_q, state_d;
  logic [N-1:0]  sel_q, sel_d;
  logic          idle_q, idle_d;
  logic [IW-1:0] last_q, last_d;

  logic [N-1:0]  pick_req;
  logic [N-1:0]  pick_gnt;
  logic [IW-1:0] pick_idx;
  logic          pick_any;
  logic          tail_hit;

  assign ack       = sel_q & req & {N{out_ready}};
  assign out_valid = |(sel_q & req);
  assign tail_hit  = |(ack & tail);
  assign sel       = sel_q;
  assign idle      = idle_q;

  // While locked, last_q is the owner g, so one
  // start index serves both arbitration paths.
  assign pick_req = (state_q == ST_LOCKED) ?
                    (req & ~sel_q) : req;

  rr_pick #(.N(N), .IW(IW)) u_pick (
    .req_i   (pick_req),
    .start_i (last_q),
    .gnt_o   (pick_gnt),
    .idx_o   (pick_idx),
    .any_o   (pick_any)
  );

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    idle_d  = idle_q;
    last_d  = last_q;
    unique case (1'b1)
      (state_q == ST_IDLE): begin
        if (pick_any) begin
          state_d = ST_LOCKED;
          sel_d   = pick_gnt;
          idle_d  = 1'b0;
          last_d  = pick_idx;
        end
      end
      default: begin
        if (tail_hit) begin
          if (pick_any) begin
            sel_d  = pick_gnt;
            last_d = pick_idx;
          end else begin
            state_d = ST_IDLE;
            sel_d   = '0;
            idle_d  = 1'b1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      sel_q   <= '0;
      idle_q  <= 1'b1;
      last_q  <= IW'(N - 1);
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      idle_q  <= idle_d;
      last_q  <= last_d;
    end
  end

endmodule

// File: doc/output_port_arbiter.md
# output_port_arbiter

Per-output-port packet arbiter that sits directly upstream of `output_data_switch`. It chooses which input channel owns the output port, using round-robin. It holds that grant for a whole packet, from head flit to tail flit. It drives the switch's one-hot `sel` and `idle` inputs, and issues per-channel pop acknowledgements against a downstream ready signal. There is one instance per router output port.

## Interface
- `NUMBER_CHANNELS`, default 5: number of input channels competing for this output. This is also the width of `sel`, `req`, `tail` and `ack`.
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `req`  in  NUMBER_CHANNELS: bit i high means channel i presents a flit destined for this output.
- `tail`  in  NUMBER_CHANNELS: bit i high means channel i's presented flit is the last of its packet. Meaningful only while `req[i]` is high.
- `out_ready`  in  1: downstream accepts a flit this cycle.
- `sel`  out  NUMBER_CHANNELS: registered one-hot grant, driven to the switch `sel` input. All zero when idle.
- `idle`  out  1: registered, high when no channel holds the port. Driven to the switch `idle` input.
- `out_valid`  out  1: combinational, equal to `|(sel & req)`. Qualifies the switch `dout`.
- `ack`  out  NUMBER_CHANNELS: combinational, equal to `sel & req & {N{out_ready}}`. Bit i pops one flit from channel i.

## Operation
- **State:**
  - FSM `ST_IDLE` / `ST_LOCKED`.
  - Grant register `sel`.
  - Round-robin pointer `last`, holding the index of the most recently granted channel.
- **Reset values:**
  - state = `ST_IDLE`
  - `sel` = 0
  - `idle` = 1
  - `last` = NUMBER_CHANNELS-1, so channel 0 has top priority after reset.
  - `ack` = 0 and `out_valid` = 0 follow from these.
- **Priority order:** `last+1`, `last+2`, …, wrapping modulo NUMBER_CHANNELS, with `last` itself lowest.
- **`ST_IDLE`:**
  - If `req` is nonzero, pick the highest-priority requesting channel g.
  - Next edge: `sel` = one-hot(g), `idle` = 0, `last` = g, state = `ST_LOCKED`.
  - Otherwise remain in `ST_IDLE`.
- **`ST_LOCKED`, granted channel g:**
  - A transfer occurs in any cycle where `ack[g]` = 1.
  - Transfer with `tail[g]` = 0: stay locked.
  - Transfer with `tail[g]` = 1, and channels other than g are requesting: re-arbitrate in the same cycle over `req & ~onehot(g)`, in priority order from g+1. Next edge: `sel` = the new winner, `last` = the new winner, stay in `ST_LOCKED`. This gives back-to-back packets with no bubble.
  - Transfer with `tail[g]` = 1, and no other channel is requesting: next edge goes to `ST_IDLE` with `sel` = 0 and `idle` = 1. Channel g may win again from `ST_IDLE` one cycle later.
  - `req[g]` low while locked (gap mid-packet): hold the grant, `out_valid` = 0, no timeout.
  - Requests from other channels never pre-empt a locked packet.
- **Reset asserted mid-packet:** immediate return to reset values. Partial-packet recovery is the upstream buffers' concern.
- **Pointer:** `last` changes only when a new grant is issued.

## Timing
- `sel` and `idle` are registered outputs. `ack` and `out_valid` are combinational from registered `sel` plus the `req` and `out_ready` inputs. There is no combinational path from `req` to `sel`.
- **Latency:** first `req` in `ST_IDLE` at cycle t gives `sel` valid at t+1. The first `ack` is at t+1, provided `out_ready` is high.
- **Throughput:** one flit per cycle while `req[g]` and `out_ready` are both high.
- **Packet switch:** the tail transfer at cycle t leads to the next packet's first `ack` at t+1.
- **Invariants:**
  - `sel` is always zero or one-hot.
  - `idle` equals `~|sel`.
  - `ack` is at most one-hot.

## Structure
- **Package `router_arb_pkg`:**
  - State encoding constants `ST_IDLE` = 1'b0 and `ST_LOCKED` = 1'b1.
  - Shared default `NUMBER_CHANNELS` = 5.
- **Sub-module `rr_pick`:**
  - Combinational, parameterised by NUMBER_CHANNELS.
  - Inputs: request vector, start index.
  - Outputs: one-hot winner, winner index, any-valid flag.
  - Instantiated once and shared by the `ST_IDLE` and tail re-arbitration paths. The input mux selects `req` with `last`, or the masked `req` with g.
- The remaining top-level logic is the FSM, the `sel`/`last` registers and the `ack` gating.

## Test plan
- **Single request:** after reset, `req`=5'b00100 with `out_ready`=1 and a 3-flit packet (tail on the 3rd) gives `sel`=00100 one cycle later. Then `ack[2]` fires on 3 consecutive cycles, followed by `sel`=0 and `idle`=1.
- **All requesting:** after reset, `req`=11111 with 1-flit packets on every channel gives the grant order 0,1,2,3,4,0 with no idle cycles between grants.
- **Back-to-back from one channel:** only ch3 requests, with two consecutive packets. Required response: one `ST_IDLE` bubble between tail and the next head, then `sel`=01000 again, `last`=3.
- **Stall:** locked on ch1, `out_ready`=0 for 4 cycles mid-packet. Required response: `ack`=0, `sel` held, `out_valid`=1 throughout. The flit count is unchanged once ready returns.
- **Request gap and no pre-emption:** locked on ch0, `req[0]` drops for 2 cycles while ch4 requests. Required response: `sel` stays 00001 and `out_valid`=0 during the gap, and ch4 is granted only after ch0's tail.
- **Reset mid-packet:** `rst_n` pulsed low while locked on ch2. Required response: `sel`=0, `idle`=1 and `ack`=0 asynchronously. After release with `req`=00110, ch1 wins (priority from 0).
